uart_rx: RTL
============

Name: uart_rx

Overview:
- Receive end of the UART link. Takes the serial line driven by the team's transmitter and rebuilds 8-bit parallel words.
- Frame format, fixed: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
- Oversamples the line at OVERSAMPLE clocks per bit, checks parity and stop bit, and emits a one-cycle Data_Valid pulse per good frame.
- Sits between the pad-side RX line and the consumer of received bytes.

Parameters:
- OVERSAMPLE, 8, clocks per bit. Even, >= 4.
- SYNC_STAGES, 2, number of flops in the RX_IN synchroniser. >= 2.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- RX_IN  in  1  asynchronous serial line; idles high.
- PAR_EN  in  1  1 = the frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  8  last correctly received byte.
- Data_Valid  out  1  one-cycle pulse; P_DATA holds a new byte.
- par_err  out  1  one-cycle pulse; parity mismatch.
- stop_err  out  1  one-cycle pulse; stop bit sampled as 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; P_DATA=0x00; Data_Valid, par_err, stop_err and busy=0; synchroniser flops=1; counters=0. Reset wins over all other events, including mid-frame; the partial frame is discarded with no pulses.
- RX_IN passes through SYNC_STAGES flops. rx_s below means the synchronised value.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within each bit and wraps to 0 at the bit boundary.
  - bit_cnt counts data bits 0..7.
- Sample point is edge_cnt == OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_s==0 -> go to START. This cycle, t0, counts as edge 0 of the start bit.
  - Latch PAR_EN and PAR_TYP for the whole frame. Changes mid-frame are ignored.
- START:
  - At the sample point, sampled 1 -> false start; return to IDLE with no pulses.
  - Sampled 0 -> at edge OVERSAMPLE-1 go to DATA with bit_cnt=0.
- DATA:
  - At the sample point, shift the sample into the shift register at position bit_cnt (LSB first).
  - At edge OVERSAMPLE-1: if bit_cnt==7, go to PARITY when the latched PAR_EN=1, otherwise to STOP. Else bit_cnt+1.
- PARITY:
  - At the sample point, store the parity bit.
  - Expected parity = XOR of the 8 data bits XOR latched PAR_TYP.
  - At edge OVERSAMPLE-1 go to STOP.
- STOP:
  - At the sample point, evaluate the frame, then return to IDLE in the same edge. The second half of the stop bit is not waited for, so an immediate next start bit is caught.
  - Sample==1 and parity OK (or parity disabled): next cycle P_DATA <= shift register and Data_Valid=1.
  - Parity mismatch: next cycle par_err=1.
  - Stop sample==0: next cycle stop_err=1.
  - Both faults can pulse together. On any error Data_Valid stays 0 and P_DATA is unchanged.
- Latency:
  - Let k = 9 with no parity, 10 with parity.
  - The stop sample occurs at t0 + k*OVERSAMPLE + OVERSAMPLE/2.
  - The pulse is registered one cycle later.
- A line held low after stop_err is treated as a new start bit on the next IDLE cycle.
- Pulse outputs are exactly one cycle wide and never overlap across frames.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value is the 2-of-3 majority of samples at edges OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The decision is applied at edge OVERSAMPLE/2+1, so the Data_Valid latency grows by 1 cycle.
  - The start-bit check also uses majority.
- Not defined: a single sample at edge OVERSAMPLE/2, with timing exactly as above.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=0, STOP_BIT=1, PAR_EVEN=0, PAR_ODD=1, DATA_W=8.
  - The transmitter also uses this package.
- One sub-module, uart_rx_sampler:
  - Contains the synchroniser, edge_cnt, and the sample/majority logic.
  - Outputs sample_valid, bit_val and bit_end strobes to the FSM.

Test Plan (OVERSAMPLE=8, macro undefined unless stated):
- Reset state: assert rst for 3 cycles mid-idle -> all outputs 0 and busy=0.
- No parity: frame 0xA5 -> P_DATA=0xA5, one Data_Valid pulse at t0+77 (stop sample t0+76), par_err=stop_err=0.
- Even parity: frame 0x3C with parity bit 0 -> Data_Valid, P_DATA=0x3C at t0+85.
  - Same frame with parity bit 1 -> par_err pulse, no Data_Valid, P_DATA unchanged.
  - Odd parity (PAR_TYP=1), frame 0x01 with parity bit 0 -> Data_Valid, P_DATA=0x01.
- Framing error: frame 0x55 with stop bit 0 -> stop_err pulse, no Data_Valid.
  - RX_IN then held low -> new frame starts, busy=1.
- False start: 3-cycle low glitch on idle line -> busy returns to 0 after the start sample; no pulses.
  - Same glitch with UART_RX_MAJORITY_VOTE_EN: a 1-cycle low at sample edge 4 inside a data bit of 0xFF -> P_DATA=0xFF.
- Reset mid-frame, then back-to-back: rst at data bit 3 -> no pulse, state IDLE.
  - Then frames 0x12 and 0x34 sent with zero idle gap -> two Data_Valid pulses 80 cycles apart, with the correct bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and helpers.
// Used by both the transmitter and the receiver (uart_rx, uart_rx_sampler).
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Frame configuration captured at the start bit and held for the frame.
  typedef struct packed {
    logic par_en;
    logic par_typ;
  } uart_cfg_t;

  // Parity bit a correct frame carries for the given data word.
  function automatic logic exp_parity(input logic [DATA_W-1:0] data,
                                      input logic              par_typ);
    logic p;
    p = 1'b0;
    unique case (par_typ)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = ^data;
    endcase
    return p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit oversample counter and bit decision strobes.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic run_i,
  output logic rx_s_o,
  output logic sample_valid_c_o,
  output logic bit_val_c_o,
  output logic bit_end_c_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_d;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];

  // Counter advances only while a frame is in flight; idle holds it at edge 0.
  always_comb begin
    edge_cnt_d = '0;
    if (run_i) begin
      edge_cnt_d = (edge_cnt_q == CNT_W'(OVERSAMPLE - 1)) ? '0
                                                          : edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign bit_end_c_o = (edge_cnt_q == CNT_W'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic early_q;
  logic mid_q;

  // Hold the two earlier votes; the third is the live sample at MID+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      if (edge_cnt_q == CNT_W'(MID - 1)) early_q <= rx_s_o;
      if (edge_cnt_q == CNT_W'(MID))     mid_q   <= rx_s_o;
    end
  end

  assign sample_valid_c_o = (edge_cnt_q == CNT_W'(MID + 1));
  assign bit_val_c_o      = majority3(early_q, mid_q, rx_s_o);
`else
  assign sample_valid_c_o = (edge_cnt_q == CNT_W'(MID));
  assign bit_val_c_o      = rx_s_o;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 / 8-parity-1 frame decoder with valid and error pulses.
// Define UART_RX_MAJORITY_VOTE_EN for 3-sample majority bit decisions.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              Data_Valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);

  uart_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  uart_cfg_t            cfg_q, cfg_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_W-1:0]    p_data_q, p_data_d;
  logic                 dv_q, dv_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 busy_q, busy_d;

  logic rx_s;
  logic sample_valid_c;
  logic bit_val_c;
  logic bit_end_c;
  logic par_ok_c;
  logic stop_ok_c;

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk              (clk),
    .rst              (rst),
    .rx_i             (RX_IN),
    .run_i            (busy_d),
    .rx_s_o           (rx_s),
    .sample_valid_c_o (sample_valid_c),
    .bit_val_c_o      (bit_val_c),
    .bit_end_c_o      (bit_end_c)
  );

  assign par_ok_c  = !cfg_q.par_en || (par_bit_q == exp_parity(shift_q, cfg_q.par_typ));
  assign stop_ok_c = (bit_val_c == STOP_BIT);

  // Frame FSM: next state, datapath updates and registered pulse requests.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    par_bit_d  = par_bit_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    par_err_d  = 1'b0;
    stop_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_d       = START;
          cfg_d.par_en  = PAR_EN;
          cfg_d.par_typ = PAR_TYP;
        end
      end

      START: begin
        if (sample_valid_c && (bit_val_c != START_BIT)) begin
          state_d = IDLE;
        end else if (bit_end_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (sample_valid_c) begin
          shift_d[bit_cnt_q] = bit_val_c;
        end
        if (bit_end_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            state_d = cfg_q.par_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (sample_valid_c) begin
          par_bit_d = bit_val_c;
        end
        if (bit_end_c) begin
          state_d = STOP;
        end
      end

      // Decide at the stop sample and leave at once so a back-to-back start is caught.
      STOP: begin
        if (sample_valid_c) begin
          state_d    = IDLE;
          par_err_d  = !par_ok_c;
          stop_err_d = !stop_ok_c;
          if (par_ok_c && stop_ok_c) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cfg_q      <= '0;
      par_bit_q  <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      par_bit_q  <= par_bit_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      busy_q     <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;
  assign busy       = busy_q;

endmodule
